runlight_ctrl: RTL and testbench

- Parametrised N-bit run-light controller driven by a rotary-encoder step pulse and/or an internal auto-run timer.
- Supports four display modes: single dot, bar graph, bounce and mirror.
- Sits between the encoder decoder (which supplies `rotated`/`dir`) and the LED bank.
- Also exports the current position and a wrap/reversal event pulse for downstream logic.

---
 rtl/runlight_ctrl.sv | 115 +++++++++++
 tb/tb_runlight_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/runlight_ctrl.sv
// Run-light controller: steps an LED position from encoder pulses or an auto-run timer
// and renders it as dot, bar, bounce or mirror pattern; exports position and wrap/reversal pulse.
module runlight_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             rotated,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             auto_en,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] light,
    output logic [PW-1:0]    pos,
    output logic             event_p
);

    localparam logic [1:0]    MODE_DOT    = 2'b00;
    localparam logic [1:0]    MODE_BAR    = 2'b01;
    localparam logic [1:0]    MODE_BOUNCE = 2'b10;
    localparam logic [1:0]    MODE_MIRROR = 2'b11;
    localparam logic [PW-1:0] POS_MAX     = PW'(WIDTH - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             auto_dir;
    logic             auto_dir_nxt;
    logic [PW-1:0]    pos_nxt;
    logic             event_nxt;
    logic [WIDTH-1:0] light_nxt;
    logic             auto_tick;
    logic             step;
    logic             step_right;
    logic             at_end;

    always_comb begin
        auto_tick    = auto_en && (cnt >= div);
        step         = rotated || auto_tick;
        step_right   = rotated ? dir : auto_dir;
        at_end       = step_right ? (pos == '0) : (pos == POS_MAX);
        cnt_nxt      = cnt;
        auto_dir_nxt = auto_dir;
        pos_nxt      = pos;
        event_nxt    = 1'b0;

        // manual pulse wins over a coincident auto tick and restarts the period
        if (rotated) begin
            cnt_nxt      = '0;
            auto_dir_nxt = dir;
        end else if (auto_tick) begin
            cnt_nxt = '0;
        end else if (auto_en) begin
            cnt_nxt = cnt + 1'b1;
        end else begin
            cnt_nxt = '0;
        end

        if (step) begin
            if (!at_end) begin
                pos_nxt = step_right ? pos - 1'b1 : pos + 1'b1;
            end else begin
                case (mode)
                    MODE_BAR: pos_nxt = pos;
                    MODE_BOUNCE: begin
                        if (!rotated) begin
                            auto_dir_nxt = ~auto_dir;
                            pos_nxt      = step_right ? pos + 1'b1 : pos - 1'b1;
                            event_nxt    = 1'b1;
                        end
                    end
                    MODE_DOT, MODE_MIRROR: begin
                        pos_nxt   = step_right ? POS_MAX : '0;
                        event_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    logic [WIDTH-1:0] one_hot;
    logic [WIDTH-1:0] mirror_hot;
    logic [PW-1:0]    mirror_pos;

    always_comb begin
        mirror_pos          = POS_MAX - pos_nxt;
        one_hot             = '0;
        one_hot[pos_nxt]    = 1'b1;
        mirror_hot          = '0;
        mirror_hot[mirror_pos] = 1'b1;
        case (mode)
            MODE_BAR:    light_nxt = one_hot | (one_hot - 1'b1);
            MODE_MIRROR: light_nxt = one_hot | mirror_hot;
            MODE_DOT, MODE_BOUNCE: light_nxt = one_hot;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= '0;
            auto_dir <= 1'b1;
            pos      <= '0;
            light    <= WIDTH'(1);
            event_p  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            auto_dir <= auto_dir_nxt;
            pos      <= pos_nxt;
            light    <= light_nxt;
            event_p  <= event_nxt;
        end
    end

endmodule

// File: tb/tb_runlight_ctrl.sv
// Scoreboard bench for runlight_ctrl: a position/step reference model queues expected
// outputs per cycle; a monitor pops and compares after each rising edge.
module tb_runlight_ctrl;

    localparam int W     = 8;
    localparam int DW    = 24;
    localparam int PWL   = $clog2(W);
    localparam logic [1:0] DOT = 2'b00, BAR = 2'b01, BOUNCE = 2'b10, MIRROR = 2'b11;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           rotated = 1'b0;
    logic           dir = 1'b0;
    logic [1:0]     mode = DOT;
    logic           auto_en = 1'b0;
    logic [DW-1:0]  div = '0;
    logic [W-1:0]   light;
    logic [PWL-1:0] pos;
    logic           event_p;

    runlight_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk(clk), .nrst(nrst), .rotated(rotated), .dir(dir), .mode(mode),
        .auto_en(auto_en), .div(div), .light(light), .pos(pos), .event_p(event_p)
    );

    always #5 clk = ~clk;

    typedef struct { int light; int pos; bit ev; } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int m_pos = 0;
    int m_cnt = 0;
    bit m_adir = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int pattern(input int p, input logic [1:0] md);
        case (md)
            BAR:     return (1 << (p + 1)) - 1;
            MIRROR:  return (1 << p) | (1 << (W - 1 - p));
            default: return 1 << p;
        endcase
    endfunction

    // One clock of stimulus; the model decides the step from the rules and queues the result.
    task automatic drive(input bit rot, input bit d, input logic [1:0] md, input bit ae, input int dv);
        bit   do_step = 0, is_auto = 0, right = 0, ev = 0;
        int   tgt;
        exp_t e;
        @(negedge clk);
        nrst = 1'b1; rotated = rot; dir = d; mode = md; auto_en = ae; div = DW'(dv);
        if (rot) begin
            do_step = 1; right = d; m_adir = d; m_cnt = 0;
        end else if (ae && m_cnt >= dv) begin
            do_step = 1; is_auto = 1; right = m_adir; m_cnt = 0;
        end else begin
            m_cnt = ae ? m_cnt + 1 : 0;
        end
        if (do_step) begin
            tgt = right ? m_pos - 1 : m_pos + 1;
            if (tgt < 0 || tgt >= W) begin
                if (md == BAR) tgt = m_pos;
                else if (md == BOUNCE) begin
                    if (is_auto) begin
                        m_adir = !m_adir; tgt = right ? m_pos + 1 : m_pos - 1; ev = 1;
                    end else tgt = m_pos;
                end else begin
                    tgt = (tgt + W) % W; ev = 1;
                end
            end
            m_pos = tgt;
        end
        e.light = pattern(m_pos, md); e.pos = m_pos; e.ev = ev;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        nrst = 1'b0; rotated = 1'b0;
        #1;
        check("rst_light", 32'(light), 1);
        check("rst_pos", 32'(pos), 0);
        check("rst_event", 32'(event_p), 0);
        m_pos = 0; m_cnt = 0; m_adir = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_light", 32'(light), 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (nrst && q.size() > 0) begin
                e = q.pop_front();
                check("mon_light", 32'(light), e.light);
                check("mon_pos", 32'(pos), e.pos);
                check("mon_event", 32'(event_p), 32'(e.ev));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] md;
        bit ae;
        int dv;

        // DOT: wrap on first right step, then walk back to 0
        do_reset();
        drive(1, 1, DOT, 0, 0);
        settle();
        check("dot_wrap_light", 32'(light), 32'h80);
        check("dot_wrap_event", 32'(event_p), 1);
        for (int i = 0; i < 7; i++) drive(1, 1, DOT, 0, 0);
        settle();
        check("dot_back_light", 32'(light), 32'h01);

        // BAR: fill then saturate, then one right
        do_reset();
        for (int i = 0; i < 9; i++) drive(1, 0, BAR, 0, 0);
        settle();
        check("bar_full_light", 32'(light), 32'hFF);
        check("bar_full_pos", 32'(pos), 7);
        drive(1, 1, BAR, 0, 0);
        settle();
        check("bar_down_light", 32'(light), 32'h7F);

        // BOUNCE auto-run with div=2
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, BOUNCE, 1, 2);
        settle();
        check("bounce_rev0_pos", 32'(pos), 1);
        check("bounce_rev0_event", 32'(event_p), 1);
        for (int i = 0; i < 21; i++) drive(0, 0, BOUNCE, 1, 2);
        settle();
        check("bounce_rev7_pos", 32'(pos), 6);
        check("bounce_rev7_event", 32'(event_p), 1);
        for (int i = 0; i < 3; i++) drive(0, 0, BOUNCE, 1, 2);
        settle();
        check("bounce_after_light", 32'(light), 32'h20);

        // MIRROR pattern and wrap
        do_reset();
        drive(0, 0, MIRROR, 0, 0);
        settle();
        check("mirror_p0", 32'(light), 32'h81);
        for (int i = 0; i < 3; i++) drive(1, 0, MIRROR, 0, 0);
        settle();
        check("mirror_p3", 32'(light), 32'h18);
        drive(1, 0, MIRROR, 0, 0);
        settle();
        check("mirror_p4", 32'(light), 32'h18);
        for (int i = 0; i < 4; i++) drive(1, 0, MIRROR, 0, 0);
        settle();
        check("mirror_wrap_pos", 32'(pos), 0);
        check("mirror_wrap_event", 32'(event_p), 1);

        // Manual pulse coincident with auto tick
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, DOT, 1, 4);
        drive(1, 0, DOT, 1, 4);
        for (int i = 0; i < 4; i++) drive(0, 0, DOT, 1, 4);
        settle();
        check("collide_hold_pos", 32'(pos), 1);
        drive(0, 0, DOT, 1, 4);
        settle();
        check("collide_next_pos", 32'(pos), 2);

        // Reset in the middle of auto-run
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 0, DOT, 1, 4);
        for (int i = 0; i < 3; i++) drive(0, 0, DOT, 1, 4);
        settle();
        check("midrst_pre_pos", 32'(pos), 5);
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, DOT, 1, 4);
        settle();
        check("midrst_wait_pos", 32'(pos), 0);
        drive(0, 0, DOT, 1, 4);
        settle();
        check("midrst_step_light", 32'(light), 32'h80);
        check("midrst_step_event", 32'(event_p), 1);

        // Randomised mix of modes, manual pulses, auto-run and resets
        md = DOT; ae = 1'b1; dv = 3;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) ae = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) dv = int'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) do_reset();
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), md, ae, dv);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
